gs_butterfly: RTL and testbench

- Gentleman-Sande (decimation-in-frequency) butterfly for the inverse NTT datapath, modulus q = 2^28 - 2^16 + 1 = 268369921.
- Computes x_out = (x + y) mod q and y_out = ((x - y) mod q) * w mod q.
- Each output can optionally be halved mod q, which folds the 1/N scaling into the inverse stages.
- w comes from a per-instance inverse-twiddle table, sequenced by an internal start-delay counter and index. It is the inverse-direction partner of the forward Cooley-Tukey butterfly and occupies the same stage slots in the INTT pipeline.

---
 rtl/gs_butterfly_if.sv | 13 +
 rtl/gs_butterfly.sv | 129 ++++++++++++
 tb/tb_gs_butterfly.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gs_butterfly_if.sv
// Operand/result bus of the Gentleman-Sande butterfly.
// The slave end is the butterfly; the master end supplies operands and consumes results.
interface gs_butterfly_if;
  logic [27:0] x_in;
  logic [27:0] y_in;
  logic        in_valid;
  logic [27:0] x_out;
  logic [27:0] y_out;
  logic        out_valid;

  modport master (output x_in, y_in, in_valid, input  x_out, y_out, out_valid);
  modport slave  (input  x_in, y_in, in_valid, output x_out, y_out, out_valid);
endinterface

// File: rtl/gs_butterfly.sv
// Gentleman-Sande (DIF) inverse-NTT butterfly mod q = 2^28 - 2^16 + 1, with its
// LAT-cycle modular multiplier and inverse-twiddle sequencer.
module modular_mult #(
  parameter int LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] a,
  input  logic [27:0] b,
  output logic [27:0] p
);
  localparam logic [28:0] Q = 29'd268369921;

  logic [55:0] prod;
  logic [44:0] f1;
  logic [33:0] f2;
  logic [28:0] f3;
  logic [27:0] reduced;
  logic [27:0] stage [LAT-1];

  // 2^28 == 2^16 - 1 (mod q), so each fold trades the high part for a
  // shifted copy minus itself; three folds leave a value below 2q.
  always_comb begin
    f1 = 45'(prod[27:0]) + (45'(prod[55:28]) << 16) - 45'(prod[55:28]);
    f2 = 34'(f1[27:0]) + (34'(f1[44:28]) << 16) - 34'(f1[44:28]);
    f3 = 29'(f2[27:0]) + (29'(f2[33:28]) << 16) - 29'(f2[33:28]);
    reduced = (f3 >= Q) ? 28'(f3 - Q) : f3[27:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod  <= '0;
      stage <= '{default: '0};
    end else begin
      prod     <= 56'(a) * 56'(b);
      stage[0] <= reduced;
      for (int i = 1; i < LAT - 1; i++) stage[i] <= stage[i-1];
    end
  end

  assign p = stage[LAT-2];
endmodule

module gs_butterfly #(
  parameter logic [7:0]        START    = 8'd6,
  parameter logic [63:0][27:0] FACTORS  = {64{28'd1}},
  parameter bit                HALVE    = 1'b0,
  parameter int                MULT_LAT = 5
) (
  input logic           clk,
  input logic           rst,
  gs_butterfly_if.slave bus
);
  localparam logic [28:0] Q = 29'd268369921;

  logic [7:0]  counter;
  logic        enable;
  logic [5:0]  index;
  logic [28:0] sum;
  logic [28:0] diff;
  logic [27:0] s_reg;
  logic [27:0] d_reg;
  logic [27:0] w_reg;
  logic        v_reg;
  logic [27:0] s_dly [MULT_LAT];
  logic        v_dly [MULT_LAT];
  logic [27:0] product;

  // Multiplying by 2^-1 mod q: odd values borrow one q so the shift is exact.
  function automatic logic [27:0] halve(input logic [27:0] v);
    return v[0] ? 28'(({1'b0, v} + Q) >> 1) : 28'(v >> 1);
  endfunction

  always_comb begin
    sum = {1'b0, bus.x_in} + {1'b0, bus.y_in};
    if (sum >= Q) sum = sum - Q;
    diff = {1'b0, bus.x_in} - {1'b0, bus.y_in};
    if (diff[28]) diff = diff + Q;
  end

  // The index advances only on accepted beats once the start delay has elapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      enable  <= (START == 8'd0);
      index   <= '0;
    end else begin
      if (counter != 8'hFF) counter <= counter + 8'd1;
      if (counter == START - 8'd1) enable <= 1'b1;
      if (enable && bus.in_valid) index <= index + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg         <= '0;
      d_reg         <= '0;
      w_reg         <= '0;
      v_reg         <= 1'b0;
      s_dly         <= '{default: '0};
      v_dly         <= '{default: 1'b0};
      bus.x_out     <= '0;
      bus.y_out     <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      s_reg    <= sum[27:0];
      d_reg    <= diff[27:0];
      w_reg    <= FACTORS[index];
      v_reg    <= bus.in_valid;
      s_dly[0] <= s_reg;
      v_dly[0] <= v_reg;
      for (int i = 1; i < MULT_LAT; i++) begin
        s_dly[i] <= s_dly[i-1];
        v_dly[i] <= v_dly[i-1];
      end
      bus.x_out     <= HALVE ? halve(s_dly[MULT_LAT-1]) : s_dly[MULT_LAT-1];
      bus.y_out     <= HALVE ? halve(product) : product;
      bus.out_valid <= v_dly[MULT_LAT-1];
    end
  end

  modular_mult #(.LAT(MULT_LAT)) u_mult (
    .clk (clk),
    .rst (rst),
    .a   (d_reg),
    .b   (w_reg),
    .p   (product)
  );
endmodule

// File: tb/tb_gs_butterfly.sv
// Bench for gs_butterfly: three instances (plain, halving, delayed start) driven in
// lockstep and compared against an arithmetic reference model of the butterfly.
module tb_gs_butterfly;
  localparam longint Q     = 64'd268369921;
  localparam int     QI    = 268369921;
  localparam int     DEPTH = 6;

  typedef struct {
    logic        v;
    logic [27:0] x;
    logic [27:0] y;
  } beat_t;

  function automatic logic [63:0][27:0] make_tab(input int mode);
    logic [63:0][27:0] t;
    for (int k = 0; k < 64; k++) begin
      if (mode == 0)      t[k] = 28'd1;
      else if (mode == 2) t[k] = 28'(k + 1);
      else if (k == 0)    t[k] = 28'd1;
      else if (k == 63)   t[k] = 28'(Q - 1);
      else                t[k] = 28'((longint'(k) * 40503 + longint'(k) * k * 977 + 5) % Q);
    end
    return t;
  endfunction

  localparam logic [63:0][27:0] TAB0 = make_tab(0);
  localparam logic [63:0][27:0] TAB1 = make_tab(1);
  localparam logic [63:0][27:0] TAB2 = make_tab(2);

  logic        clk;
  logic        rst;
  logic        v_drv;
  logic [27:0] x_drv;
  logic [27:0] y_drv;
  int          checks;
  int          failures;
  int          since  [3];
  int          ebeats [3];
  beat_t       line   [3][DEPTH];
  beat_t       expv   [3];
  logic        obs_v  [3];
  logic [27:0] obs_x  [3];
  logic [27:0] obs_y  [3];

  gs_butterfly_if bus_a ();
  gs_butterfly_if bus_b ();
  gs_butterfly_if bus_c ();

  assign bus_a.x_in = x_drv;  assign bus_a.y_in = y_drv;  assign bus_a.in_valid = v_drv;
  assign bus_b.x_in = x_drv;  assign bus_b.y_in = y_drv;  assign bus_b.in_valid = v_drv;
  assign bus_c.x_in = x_drv;  assign bus_c.y_in = y_drv;  assign bus_c.in_valid = v_drv;
  assign obs_v[0] = bus_a.out_valid;  assign obs_x[0] = bus_a.x_out;  assign obs_y[0] = bus_a.y_out;
  assign obs_v[1] = bus_b.out_valid;  assign obs_x[1] = bus_b.x_out;  assign obs_y[1] = bus_b.y_out;
  assign obs_v[2] = bus_c.out_valid;  assign obs_x[2] = bus_c.x_out;  assign obs_y[2] = bus_c.y_out;

  gs_butterfly #(.START(8'd0), .FACTORS(TAB0), .HALVE(1'b0)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  gs_butterfly #(.START(8'd0), .FACTORS(TAB1), .HALVE(1'b1)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
  gs_butterfly #(.START(8'd2), .FACTORS(TAB2), .HALVE(1'b0)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int start_of(input int i);
    return (i == 2) ? 2 : 0;
  endfunction

  function automatic longint fac(input int i, input int k);
    if (i == 0) return longint'(TAB0[k]);
    if (i == 1) return longint'(TAB1[k]);
    return longint'(TAB2[k]);
  endfunction

  function automatic longint half(input longint v);
    return (v % 2 == 0) ? v / 2 : (v + Q) / 2;
  endfunction

  function automatic beat_t ref_beat(input int i, input logic v, input longint x,
                                     input longint y, input longint w);
    beat_t  b;
    longint s;
    longint p;
    s = (x + y) % Q;
    p = (((x - y + Q) % Q) * w) % Q;
    if (i == 1) begin
      s = half(s);
      p = half(p);
    end
    b.v = v;
    b.x = 28'(s);
    b.y = 28'(p);
    return b;
  endfunction

  function automatic logic [27:0] rand_operand();
    int r;
    r = int'($urandom_range(9, 0));
    if (r == 0) return 28'd0;
    if (r == 1) return 28'(QI - 1);
    return 28'($urandom_range(QI - 1, 0));
  endfunction

  // One clock: drive inputs, advance the model, and expose the beat due at the outputs now.
  task automatic cycle(input logic r, input logic v, input logic [27:0] x, input logic [27:0] y);
    beat_t nb;
    rst = r; v_drv = v; x_drv = x; y_drv = y;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        since[i]  = 0;
        ebeats[i] = 0;
        for (int j = 0; j < DEPTH; j++) line[i][j] = '{1'b0, 28'd0, 28'd0};
        expv[i] = '{1'b0, 28'd0, 28'd0};
      end else begin
        nb = ref_beat(i, v, longint'(x), longint'(y), fac(i, ebeats[i] % 64));
        if (since[i] >= start_of(i) && v) ebeats[i]++;
        since[i]++;
        expv[i] = line[i][0];
        for (int j = 0; j < DEPTH - 1; j++) line[i][j] = line[i][j+1];
        line[i][DEPTH-1] = nb;
      end
    end
  endtask

  task automatic test_reset();
    for (int n = 0; n < 3; n++) cycle(1'b1, 1'b0, 28'd0, 28'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_v[i] !== 1'b0 || obs_x[i] !== 28'd0 || obs_y[i] !== 28'd0) begin
        failures++;
        $display("[TB] FAIL reset dut%0d: got v=%b x=%0d y=%0d want v=0 x=0 y=0",
                 i, obs_v[i], obs_x[i], obs_y[i]);
      end
    end
  endtask

  task automatic test_fixed_vectors();
    logic [27:0] xs [5];
    logic [27:0] ys [5];
    logic [27:0] got_x [2][5];
    logic [27:0] got_y [2][5];
    int          cnt [2];
    xs = '{28'd5, 28'd6, 28'd5, 28'd3, 28'(QI - 1)};
    ys = '{28'd2, 28'd2, 28'd3, 28'd5, 28'd1};
    cnt = '{0, 0};
    cycle(1'b1, 1'b0, 28'd0, 28'd0);
    for (int n = 0; n < 14; n++) begin
      if (n < 5) cycle(1'b0, 1'b1, xs[n], ys[n]);
      else       cycle(1'b0, 1'b0, 28'd0, 28'd0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_v[i] !== expv[i].v) begin
          failures++;
          $display("[TB] FAIL fixed out_valid dut%0d: got %b want %b", i, obs_v[i], expv[i].v);
        end
        if (expv[i].v) begin
          checks++;
          if (obs_x[i] !== expv[i].x || obs_y[i] !== expv[i].y) begin
            failures++;
            $display("[TB] FAIL fixed data dut%0d: got x=%0d y=%0d want x=%0d y=%0d",
                     i, obs_x[i], obs_y[i], expv[i].x, expv[i].y);
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (obs_v[i] === 1'b1 && cnt[i] < 5) begin
          got_x[i][cnt[i]] = obs_x[i];
          got_y[i][cnt[i]] = obs_y[i];
          cnt[i]++;
        end
      end
    end
    checks++;
    if (cnt[0] != 5 || cnt[1] != 5) begin
      failures++;
      $display("[TB] FAIL fixed beat count: got %0d/%0d want 5/5", cnt[0], cnt[1]);
    end else begin
      checks++;
      if (got_x[0][2] !== 28'd8 || got_y[0][2] !== 28'd2) begin
        failures++;
        $display("[TB] FAIL fixed 5-3: got x=%0d y=%0d want x=8 y=2", got_x[0][2], got_y[0][2]);
      end
      checks++;
      if (got_y[0][3] !== 28'd268369919) begin
        failures++;
        $display("[TB] FAIL fixed 3-5 wrap: got y=%0d want 268369919", got_y[0][3]);
      end
      checks++;
      if (got_x[0][4] !== 28'd0 || got_y[0][4] !== 28'd268369919) begin
        failures++;
        $display("[TB] FAIL fixed q-1+1: got x=%0d y=%0d want x=0 y=268369919", got_x[0][4], got_y[0][4]);
      end
      checks++;
      if (got_x[1][0] !== 28'd134184964 || got_y[1][0] !== 28'd134184962) begin
        failures++;
        $display("[TB] FAIL fixed halve odd: got x=%0d y=%0d want x=134184964 y=134184962",
                 got_x[1][0], got_y[1][0]);
      end
      checks++;
      if (got_x[1][1] !== 28'd4) begin
        failures++;
        $display("[TB] FAIL fixed halve even: got x=%0d want 4", got_x[1][1]);
      end
    end
  endtask

  task automatic test_random_stream();
    cycle(1'b1, 1'b0, 28'd0, 28'd0);
    for (int n = 0; n < 220; n++) begin
      if (n < 200) cycle(1'b0, ($urandom_range(3, 0) != 0), rand_operand(), rand_operand());
      else         cycle(1'b0, 1'b0, 28'd0, 28'd0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_v[i] !== expv[i].v) begin
          failures++;
          $display("[TB] FAIL random out_valid dut%0d: got %b want %b", i, obs_v[i], expv[i].v);
        end
        if (expv[i].v) begin
          checks++;
          if (obs_x[i] !== expv[i].x || obs_y[i] !== expv[i].y) begin
            failures++;
            $display("[TB] FAIL random data dut%0d: got x=%0d y=%0d want x=%0d y=%0d",
                     i, obs_x[i], obs_y[i], expv[i].x, expv[i].y);
          end
        end
      end
    end
  endtask

  task automatic test_twiddle_sequence();
    int ys [80];
    int cnt;
    int at   [7];
    int want [7];
    at   = '{0, 1, 2, 3, 4, 66, 67};
    want = '{1, 1, 1, 2, 3, 1, 2};
    cnt  = 0;
    cycle(1'b1, 1'b0, 28'd0, 28'd0);
    for (int n = 0; n < 88; n++) begin
      if (n < 80) cycle(1'b0, 1'b1, 28'd1, 28'd0);
      else        cycle(1'b0, 1'b0, 28'd0, 28'd0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_v[i] !== expv[i].v) begin
          failures++;
          $display("[TB] FAIL twiddle out_valid dut%0d: got %b want %b", i, obs_v[i], expv[i].v);
        end
        if (expv[i].v) begin
          checks++;
          if (obs_x[i] !== expv[i].x || obs_y[i] !== expv[i].y) begin
            failures++;
            $display("[TB] FAIL twiddle data dut%0d: got x=%0d y=%0d want x=%0d y=%0d",
                     i, obs_x[i], obs_y[i], expv[i].x, expv[i].y);
          end
        end
      end
      if (obs_v[2] === 1'b1 && cnt < 80) begin
        ys[cnt] = int'(obs_y[2]);
        cnt++;
      end
    end
    checks++;
    if (cnt != 80) begin
      failures++;
      $display("[TB] FAIL twiddle beat count: got %0d want 80", cnt);
    end else begin
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (ys[at[k]] != want[k]) begin
          failures++;
          $display("[TB] FAIL twiddle seq[%0d]: got %0d want %0d", at[k], ys[at[k]], want[k]);
        end
      end
    end
  endtask

  task automatic test_gapped_valid();
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    cycle(1'b1, 1'b0, 28'd0, 28'd0);
    for (int n = 0; n < 12; n++) begin
      if (n < 4) cycle(1'b0, pat[n], 28'd1, 28'd0);
      else       cycle(1'b0, 1'b0, 28'd0, 28'd0);
      if (n >= 6 && n < 10) begin
        checks++;
        if (obs_v[0] !== pat[n-6]) begin
          failures++;
          $display("[TB] FAIL gapped pattern[%0d]: got %b want %b", n - 6, obs_v[0], pat[n-6]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_v[i] !== expv[i].v) begin
          failures++;
          $display("[TB] FAIL gapped out_valid dut%0d: got %b want %b", i, obs_v[i], expv[i].v);
        end
        if (expv[i].v) begin
          checks++;
          if (obs_x[i] !== expv[i].x || obs_y[i] !== expv[i].y) begin
            failures++;
            $display("[TB] FAIL gapped data dut%0d: got x=%0d y=%0d want x=%0d y=%0d",
                     i, obs_x[i], obs_y[i], expv[i].x, expv[i].y);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    cycle(1'b1, 1'b0, 28'd0, 28'd0);
    for (int n = 0; n < 25; n++) begin
      if (n < 5)       cycle(1'b0, 1'b1, rand_operand(), rand_operand());
      else if (n == 5) cycle(1'b1, 1'b1, rand_operand(), rand_operand());
      else if (n == 6) cycle(1'b0, 1'b1, 28'd1, 28'd0);
      else if (n < 11) cycle(1'b0, 1'b1, rand_operand(), rand_operand());
      else             cycle(1'b0, 1'b0, 28'd0, 28'd0);
      if (n >= 5 && n < 12) begin
        checks++;
        if (obs_v[0] !== 1'b0) begin
          failures++;
          $display("[TB] FAIL midreset flush +%0d: got out_valid=%b want 0", n - 5, obs_v[0]);
        end
      end
      if (n == 12) begin
        checks++;
        if (obs_v[1] !== 1'b1 || obs_x[1] !== 28'd134184961 || obs_y[1] !== 28'd134184961) begin
          failures++;
          $display("[TB] FAIL midreset first beat: got v=%b x=%0d y=%0d want v=1 x=134184961 y=134184961",
                   obs_v[1], obs_x[1], obs_y[1]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_v[i] !== expv[i].v) begin
          failures++;
          $display("[TB] FAIL midreset out_valid dut%0d: got %b want %b", i, obs_v[i], expv[i].v);
        end
        if (expv[i].v) begin
          checks++;
          if (obs_x[i] !== expv[i].x || obs_y[i] !== expv[i].y) begin
            failures++;
            $display("[TB] FAIL midreset data dut%0d: got x=%0d y=%0d want x=%0d y=%0d",
                     i, obs_x[i], obs_y[i], expv[i].x, expv[i].y);
          end
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    v_drv = 1'b0;
    x_drv = 28'd0;
    y_drv = 28'd0;
    test_reset();
    test_fixed_vectors();
    test_random_stream();
    test_twiddle_sequence();
    test_gapped_valid();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
